// File: rtl/cmd_issuer_if.sv
// Host command enqueue channel: valid/ready push handshake into the issuer FIFO.
interface cmd_issuer_if #(
  parameter int OPSIZE = 6
);
  logic [OPSIZE-1:0] host_cmd;
  logic              host_valid;
  logic              host_ready;

  // host side drives commands
  modport master (output host_cmd, output host_valid, input host_ready);
  // issuer side accepts them
  modport slave  (input host_cmd, input host_valid, output host_ready);
endinterface

// File: rtl/cmd_issuer.sv
// Command source for the ALU control FSM: FIFO of host commands, a phase
// register shadowing the control FSM, one command per 3-cycle slot, and
// per-command completion/error reporting sampled in EXEC.
module cmd_issuer #(
  parameter int                OPSIZE   = 6,
  parameter int                DEPTH    = 4,
  parameter int                CNTW     = 8,
  parameter logic [OPSIZE-1:0] IDLE_CMD = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cmd_issuer_if.slave              host,
  input  logic                     en,
  input  logic                     resync,
  input  logic                     clr_cnt,
  input  logic                     nvalid_data,
  output logic                     ctrl_rst,
  output logic [OPSIZE-1:0]        cmd_out,
  output logic                     slot_busy,
  output logic                     cmd_done,
  output logic                     cmd_err,
  output logic [CNTW-1:0]          issued_cnt,
  output logic [CNTW-1:0]          err_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {PH_INIT, PH_RST, PH_FETCH, PH_LOAD, PH_EXEC} ph_t;

  ph_t                          ph;
  logic [DEPTH-1:0][OPSIZE-1:0] mem;
  logic [AW-1:0]                wr_ptr, rd_ptr;
  logic                         push, pop, load, fin;

  // next edge enters FETCH (slot load) / closes an EXEC (completion);
  // resync overrides both so the in-flight slot is dropped silently
  assign load = !resync && (ph == PH_RST || ph == PH_EXEC);
  assign fin  = !resync && (ph == PH_EXEC);
  // pop only from registered occupancy: a same-edge push is never bypassed
  assign pop  = load && en && (fifo_level != '0);
  assign push = host.host_valid && host.host_ready;
  assign host.host_ready = (fifo_level < FULL_LVL);

  // FIFO storage, no reset needed: only entries below fifo_level are read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= host.host_cmd;
  end

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^AW)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
        2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // phase FSM with registered slot outputs and completion pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph        <= PH_INIT;
      ctrl_rst  <= 1'b1;
      cmd_out   <= IDLE_CMD;
      slot_busy <= 1'b0;
      cmd_done  <= 1'b0;
      cmd_err   <= 1'b0;
    end else if (resync) begin
      ph        <= PH_INIT;
      ctrl_rst  <= 1'b1;
      cmd_out   <= IDLE_CMD;
      slot_busy <= 1'b0;
      cmd_done  <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      ctrl_rst <= 1'b0;
      cmd_done <= fin && slot_busy;
      cmd_err  <= fin && slot_busy && nvalid_data;
      if (load) begin
        cmd_out   <= pop ? mem[rd_ptr] : IDLE_CMD;
        slot_busy <= pop;
      end
      case (ph)
        PH_INIT:  ph <= PH_RST;
        PH_RST:   ph <= PH_FETCH;
        PH_FETCH: ph <= PH_LOAD;
        PH_LOAD:  ph <= PH_EXEC;
        PH_EXEC:  ph <= PH_FETCH;
        default:  ph <= PH_INIT;
      endcase
    end
  end

  // saturating completion counters; clear wins over a coincident increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_cnt <= '0;
      err_cnt    <= '0;
    end else if (clr_cnt) begin
      issued_cnt <= '0;
      err_cnt    <= '0;
    end else if (fin && slot_busy) begin
      if (issued_cnt != '1)                 issued_cnt <= issued_cnt + CNTW'(1);
      if (nvalid_data && (err_cnt != '1))   err_cnt    <= err_cnt + CNTW'(1);
    end
  end
endmodule

// File: tb/tb_cmd_issuer.sv
// Self-checking bench for cmd_issuer: directed vector table, hand sequences
// for resync/clear/reset corners, and random traffic against a queue model.
// A second instance with CNTW=2 shares every input to exercise saturation.
module tb_cmd_issuer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0, resync = 1'b0, clr_cnt = 1'b0, nvalid_data = 1'b0;
  logic       ctrl_rst, slot_busy, cmd_done, cmd_err;
  logic [5:0] cmd_out;
  logic [7:0] issued_cnt, err_cnt;
  logic [2:0] fifo_level;
  logic       ctrl_rst2, slot_busy2, cmd_done2, cmd_err2;
  logic [5:0] cmd_out2;
  logic [1:0] issued_cnt2, err_cnt2;
  logic [2:0] fifo_level2;

  cmd_issuer_if #(.OPSIZE(6)) if1 ();
  cmd_issuer_if #(.OPSIZE(6)) if2 ();

  cmd_issuer #(.OPSIZE(6), .DEPTH(DEPTH), .CNTW(8)) dut (
    .clk(clk), .rst_n(rst_n), .host(if1.slave), .en(en), .resync(resync),
    .clr_cnt(clr_cnt), .nvalid_data(nvalid_data), .ctrl_rst(ctrl_rst),
    .cmd_out(cmd_out), .slot_busy(slot_busy), .cmd_done(cmd_done), .cmd_err(cmd_err),
    .issued_cnt(issued_cnt), .err_cnt(err_cnt), .fifo_level(fifo_level));

  cmd_issuer #(.OPSIZE(6), .DEPTH(DEPTH), .CNTW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .host(if2.slave), .en(en), .resync(resync),
    .clr_cnt(clr_cnt), .nvalid_data(nvalid_data), .ctrl_rst(ctrl_rst2),
    .cmd_out(cmd_out2), .slot_busy(slot_busy2), .cmd_done(cmd_done2), .cmd_err(cmd_err2),
    .issued_cnt(issued_cnt2), .err_cnt(err_cnt2), .fifo_level(fifo_level2));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // reference model: phase 0..4 = INIT,RST,FETCH,LOAD,EXEC
  int         m_ph;
  logic [5:0] q[$];
  logic [5:0] m_cmd;
  bit         m_busy, m_done, m_err, m_crst;
  int         m_iss, m_erc, m_iss2, m_erc2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic check_all();
    chk("ctrl_rst",    32'(ctrl_rst),    32'(m_crst));
    chk("cmd_out",     32'(cmd_out),     32'(m_cmd));
    chk("slot_busy",   32'(slot_busy),   32'(m_busy));
    chk("cmd_done",    32'(cmd_done),    32'(m_done));
    chk("cmd_err",     32'(cmd_err),     32'(m_err));
    chk("issued_cnt",  32'(issued_cnt),  32'(m_iss));
    chk("err_cnt",     32'(err_cnt),     32'(m_erc));
    chk("fifo_level",  32'(fifo_level),  32'(q.size()));
    chk("host_ready",  32'(if1.host_ready), 32'(q.size() < DEPTH));
    chk("issued_cnt2", 32'(issued_cnt2), 32'(m_iss2));
    chk("err_cnt2",    32'(err_cnt2),    32'(m_erc2));
    chk("cmd_done2",   32'(cmd_done2),   32'(m_done));
  endtask

  task automatic model_reset();
    m_ph = 0; m_cmd = '0; m_busy = 0; m_done = 0; m_err = 0; m_crst = 1;
    m_iss = 0; m_erc = 0; m_iss2 = 0; m_erc2 = 0;
    q.delete();
  endtask

  // one clock: drive inputs, advance the model, check after the edge
  task automatic step(input bit hv, input logic [5:0] hc, input bit e,
                      input bit rs, input bit cl, input bit nv);
    bit push, fin, ld, nd, ne;
    if1.host_valid = hv; if1.host_cmd = hc;
    if2.host_valid = hv; if2.host_cmd = hc;
    en = e; resync = rs; clr_cnt = cl; nvalid_data = nv;
    push = hv && (q.size() < DEPTH);
    fin  = !rs && (m_ph == 4);
    ld   = !rs && (m_ph == 1 || m_ph == 4);
    nd   = fin && m_busy;
    ne   = nd && nv;
    if (rs) begin
      m_ph = 0; m_cmd = '0; m_busy = 0;
    end else begin
      m_ph = (m_ph == 4) ? 2 : m_ph + 1;
      if (ld) begin
        if (e && q.size() > 0) begin m_cmd = q.pop_front(); m_busy = 1; end
        else begin m_cmd = '0; m_busy = 0; end
      end
    end
    if (push) q.push_back(hc);
    m_done = nd; m_err = ne; m_crst = (m_ph == 0);
    if (cl) begin
      m_iss = 0; m_erc = 0; m_iss2 = 0; m_erc2 = 0;
    end else begin
      m_iss  = (m_iss  + int'(nd) > 255) ? 255 : m_iss  + int'(nd);
      m_erc  = (m_erc  + int'(ne) > 255) ? 255 : m_erc  + int'(ne);
      m_iss2 = (m_iss2 + int'(nd) > 3)   ? 3   : m_iss2 + int'(nd);
      m_erc2 = (m_erc2 + int'(ne) > 3)   ? 3   : m_erc2 + int'(ne);
    end
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic idle(input bit e);
    step(0, 6'd0, e, 0, 0, 0);
  endtask

  // asynchronous reset asserted mid-cycle, released away from the edge
  task automatic do_reset();
    #3 rst_n = 1'b0;
    if1.host_valid = 0; if2.host_valid = 0;
    en = 0; resync = 0; clr_cnt = 0; nvalid_data = 0;
    #1 model_reset();
    check_all();
    repeat (2) @(posedge clk);
    #1 check_all();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit hv; logic [5:0] hc; bit e; bit nv;
    bit crst; logic [5:0] cmd; bit busy; bit done; bit err; int lvl; int iss; int erc;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [5:0] ca, cb, cc;
    int k, lvl;
    ca = 6'b011000; cb = 6'b110011; cc = 6'b000101;
    // row k is applied before edge k+1 after reset release
    tbl[0]  = '{1, ca, 1, 0,  0, 6'd0, 0, 0, 0, 1, 0, 0};
    tbl[1]  = '{1, cb, 1, 0,  0, ca,   1, 0, 0, 1, 0, 0};
    tbl[2]  = '{1, cc, 1, 0,  0, ca,   1, 0, 0, 2, 0, 0};
    tbl[3]  = '{0, 0,  1, 0,  0, ca,   1, 0, 0, 2, 0, 0};
    tbl[4]  = '{0, 0,  1, 0,  0, cb,   1, 1, 0, 1, 1, 0};
    tbl[5]  = '{0, 0,  1, 0,  0, cb,   1, 0, 0, 1, 1, 0};
    tbl[6]  = '{0, 0,  1, 0,  0, cb,   1, 0, 0, 1, 1, 0};
    tbl[7]  = '{0, 0,  1, 0,  0, cc,   1, 1, 0, 0, 2, 0};
    tbl[8]  = '{0, 0,  1, 0,  0, cc,   1, 0, 0, 0, 2, 0};
    tbl[9]  = '{0, 0,  1, 0,  0, cc,   1, 0, 0, 0, 2, 0};
    tbl[10] = '{0, 0,  1, 1,  0, 6'd0, 0, 1, 1, 0, 3, 1};
    tbl[11] = '{0, 0,  1, 0,  0, 6'd0, 0, 0, 0, 0, 3, 1};
    tbl[12] = '{0, 0,  1, 0,  0, 6'd0, 0, 0, 0, 0, 3, 1};
    tbl[13] = '{0, 0,  1, 1,  0, 6'd0, 0, 0, 0, 0, 3, 1};

    if1.host_valid = 0; if1.host_cmd = '0; if2.host_valid = 0; if2.host_cmd = '0;
    @(posedge clk); #1;
    do_reset();

    // directed: prologue, three commands, busy-slot error, bubble-slot error
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].hv, tbl[i].hc, tbl[i].e, 0, 0, tbl[i].nv);
      chk($sformatf("tbl%0d_crst", i), 32'(ctrl_rst),   32'(tbl[i].crst));
      chk($sformatf("tbl%0d_cmd", i),  32'(cmd_out),    32'(tbl[i].cmd));
      chk($sformatf("tbl%0d_busy", i), 32'(slot_busy),  32'(tbl[i].busy));
      chk($sformatf("tbl%0d_done", i), 32'(cmd_done),   32'(tbl[i].done));
      chk($sformatf("tbl%0d_err", i),  32'(cmd_err),    32'(tbl[i].err));
      chk($sformatf("tbl%0d_lvl", i),  32'(fifo_level), 32'(tbl[i].lvl));
      chk($sformatf("tbl%0d_iss", i),  32'(issued_cnt), 32'(tbl[i].iss));
      chk($sformatf("tbl%0d_erc", i),  32'(err_cnt),    32'(tbl[i].erc));
    end

    // fill while disabled: 4 accepted, 5th refused
    for (int i = 0; i < 5; i++) begin
      step(1, 6'(8 + i), 0, 0, 0, 0);
      if (i >= 3) begin
        chk("full_ready", 32'(if1.host_ready), 32'd0);
        chk("full_level", 32'(fifo_level), 32'd4);
      end
    end
    step(0, 6'd0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) idle(1);
    chk("drain_level", 32'(fifo_level), 32'd0);
    chk("drain_issued", 32'(issued_cnt), 32'd7);
    chk("sat_issued2", 32'(issued_cnt2), 32'd3);

    // resync during LOAD of a busy slot
    step(1, 6'h2a, 1, 0, 0, 0);
    step(1, 6'h15, 1, 0, 0, 0);
    k = 0;
    while (!(m_ph == 3 && m_busy) && k < 30) begin idle(1); k++; end
    chk("wait_load_busy", 32'(k < 30), 32'd1);
    lvl = q.size();
    step(0, 6'd0, 1, 1, 0, 0);
    chk("resync_crst", 32'(ctrl_rst), 32'd1);
    chk("resync_busy", 32'(slot_busy), 32'd0);
    chk("resync_lvl", 32'(fifo_level), 32'(lvl));
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("resync_nodone", 32'(cmd_done), 32'd0);
    end
    chk("resync_crst_off", 32'(ctrl_rst), 32'd0);
    for (int i = 0; i < 12; i++) idle(1);

    // random traffic, with an async reset in the middle
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      step($urandom_range(0, 1) == 1, 6'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 49) == 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 2) == 0);
    end

    // clear coinciding with a completion: pulse seen, counters zero
    step(1, 6'h33, 1, 0, 0, 0);
    k = 0;
    while (!(m_ph == 4 && m_busy) && k < 30) begin idle(1); k++; end
    chk("wait_exec_busy", 32'(k < 30), 32'd1);
    step(0, 6'd0, 1, 0, 1, 1);
    chk("clr_done", 32'(cmd_done), 32'd1);
    chk("clr_err", 32'(cmd_err), 32'd1);
    chk("clr_issued", 32'(issued_cnt), 32'd0);
    chk("clr_err_cnt", 32'(err_cnt), 32'd0);
    chk("clr_issued2", 32'(issued_cnt2), 32'd0);
    for (int i = 0; i < 6; i++) idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
